// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Iterative MIPS multiply/divide unit owning the HI/LO registers.
//            Define MULDIV_FAST_MUL_EN for a single-cycle MULT/MULTU path.
// Revision : 1.0  initial release
// ============================================================================
module muldiv_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rsdata,
    input  logic [31:0] rtdata,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] c_OP_MULT  = 3'b000;
    localparam logic [2:0] c_OP_MULTU = 3'b001;
    localparam logic [2:0] c_OP_DIV   = 3'b010;
    localparam logic [2:0] c_OP_DIVU  = 3'b011;
    localparam logic [2:0] c_OP_MTHI  = 3'b100;
    localparam logic [2:0] c_OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIX = 2'd2} state_t;

    state_t      r_state;
    logic [31:0] r_hi, r_lo;
    logic        r_busy, r_done, r_dbz;
    logic [4:0]  r_cnt;
    logic        r_is_div;
    logic        r_neg_lo, r_neg_hi;
    logic [31:0] r_b;
    logic [63:0] r_acc;

    logic        w_signed;
    logic [31:0] w_mag_a, w_mag_b;
    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_step;
    logic [32:0] w_rem_sh, w_rem_sub;
    logic        w_div_ge;
    logic [63:0] w_div_step;
    logic [63:0] w_prod_fix;

    assign w_signed = ~op[0];
    assign w_mag_a  = (w_signed && rsdata[31]) ? (32'd0 - rsdata) : rsdata;
    assign w_mag_b  = (w_signed && rtdata[31]) ? (32'd0 - rtdata) : rtdata;

    // Shift-add: upper half accumulates, multiplier bits drain out of the low half.
    assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_b} : 33'd0);
    assign w_mul_step = {w_mul_sum, r_acc[31:1]};

    // Restoring step: remainder in the upper half, quotient shifts into the low half.
    assign w_rem_sh   = r_acc[63:31];
    assign w_rem_sub  = w_rem_sh - {1'b0, r_b};
    assign w_div_ge   = ~w_rem_sub[32];
    assign w_div_step = {(w_div_ge ? w_rem_sub[31:0] : w_rem_sh[31:0]), r_acc[30:0], w_div_ge};

    assign w_prod_fix = r_neg_lo ? (64'd0 - r_acc) : r_acc;

`ifdef MULDIV_FAST_MUL_EN
    logic [63:0] w_fast_prod;
    assign w_fast_prod = op[0] ? ({32'd0, rsdata} * {32'd0, rtdata})
                               : ({{32{rsdata[31]}}, rsdata} * {{32{rtdata[31]}}, rtdata});
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_dbz    <= 1'b0;
            r_cnt    <= 5'd0;
            r_is_div <= 1'b0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_b      <= 32'd0;
            r_acc    <= 64'd0;
        end else begin
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        case (op)
                            c_OP_MTHI: begin
                                r_hi   <= rsdata;
                                r_done <= 1'b1;
                            end
                            c_OP_MTLO: begin
                                r_lo   <= rsdata;
                                r_done <= 1'b1;
                            end
`ifdef MULDIV_FAST_MUL_EN
                            c_OP_MULT, c_OP_MULTU: begin
                                r_hi   <= w_fast_prod[63:32];
                                r_lo   <= w_fast_prod[31:0];
                                r_done <= 1'b1;
                            end
`endif
                            c_OP_DIV, c_OP_DIVU: begin
                                if (rtdata == 32'd0) begin
                                    r_done <= 1'b1;
                                    r_dbz  <= 1'b1;
                                end else begin
                                    r_is_div <= 1'b1;
                                    r_b      <= w_mag_b;
                                    r_acc    <= {32'd0, w_mag_a};
                                    r_neg_lo <= w_signed & (rsdata[31] ^ rtdata[31]);
                                    r_neg_hi <= w_signed & rsdata[31];
                                    r_cnt    <= 5'd0;
                                    r_busy   <= 1'b1;
                                    r_state  <= S_RUN;
                                end
                            end
                            default: begin
                                // Iterative multiply in the default build; reserved ops fall through idle.
                                if (op == c_OP_MULT || op == c_OP_MULTU) begin
                                    r_is_div <= 1'b0;
                                    r_b      <= w_mag_b;
                                    r_acc    <= {32'd0, w_mag_a};
                                    r_neg_lo <= w_signed & (rsdata[31] ^ rtdata[31]);
                                    r_neg_hi <= 1'b0;
                                    r_cnt    <= 5'd0;
                                    r_busy   <= 1'b1;
                                    r_state  <= S_RUN;
                                end
                            end
                        endcase
                    end
                end
                S_RUN: begin
                    r_acc <= r_is_div ? w_div_step : w_mul_step;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (r_is_div) begin
                        r_lo <= r_neg_lo ? (32'd0 - r_acc[31:0])  : r_acc[31:0];
                        r_hi <= r_neg_hi ? (32'd0 - r_acc[63:32]) : r_acc[63:32];
                    end else begin
                        r_lo <= w_prod_fix[31:0];
                        r_hi <= w_prod_fix[63:32];
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign div_by_zero = r_dbz;
    assign hi          = r_hi;
    assign lo          = r_lo;

endmodule
`default_nettype wire
